// File: rtl/dm9000a_pkg.sv
// Shared types and constants for the DM9000A bus controller: FSM states,
// bus phase codes, register indices and CMD pin levels.
package dm9000a_pkg;

   typedef enum logic [3:0] {
      RST_HOLD,
      RST_WAIT,
      IDLE,
      IDX_SETUP,
      IDX_STROBE,
      IDX_HOLD,
      DAT_SETUP,
      DAT_STROBE,
      DAT_HOLD,
      RECOVER,
      RESP
   } state_e;

   typedef enum logic [1:0] {
      PH_NONE,
      PH_SETUP,
      PH_STROBE,
      PH_HOLD
   } phase_e;

   localparam logic CMD_INDEX = 1'b0;
   localparam logic CMD_DATA  = 1'b1;

   localparam logic [7:0] REG_NCR   = 8'h00;
   localparam logic [7:0] REG_NSR   = 8'h01;
   localparam logic [7:0] REG_TCR   = 8'h02;
   localparam logic [7:0] REG_ISR   = 8'hFE;
   localparam logic [7:0] REG_IMR   = 8'hFF;
   localparam logic [7:0] REG_MWCMD = 8'hF8;
   localparam logic [7:0] REG_MRCMD = 8'hF2;
   localparam logic [7:0] REG_VID   = 8'h28;

   // Both the index and the data phase map onto the same setup/strobe/hold timing.
   function automatic phase_e phase_of(input state_e s);
      case (s)
         IDX_SETUP, DAT_SETUP:   phase_of = PH_SETUP;
         IDX_STROBE, DAT_STROBE: phase_of = PH_STROBE;
         IDX_HOLD, DAT_HOLD:     phase_of = PH_HOLD;
         default:                phase_of = PH_NONE;
      endcase
   endfunction

endpackage

// File: rtl/dm9000a_bus_phase.sv
// Setup/strobe/hold timer for one chip bus cycle; registers CS_N, the
// selected strobe and the data output enable from the requested phase.
module dm9000a_bus_phase
   import dm9000a_pkg::*;
#(
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 3,
   parameter int HOLD_CYCLES   = 1
) (
   input  logic   clk,
   input  logic   rst_n,
   input  phase_e phase_i,
   input  logic   write_i,
   output logic   cs_n_o,
   output logic   rd_n_o,
   output logic   wr_n_o,
   output logic   oe_o,
   output logic   last_o
);

   phase_e     phase_q;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] len;

   // The counter restarts whenever the phase changes, so last_o marks the final cycle of the current phase.
   always_comb begin
      len = 8'd1;
      case (phase_q)
         PH_SETUP:  len = 8'(SETUP_CYCLES);
         PH_STROBE: len = 8'(STROBE_CYCLES);
         PH_HOLD:   len = 8'(HOLD_CYCLES);
         default:   len = 8'd1;
      endcase
      last_o = (phase_q != PH_NONE) && (cnt_q == len - 8'd1);
      cnt_d  = (phase_i != phase_q) ? 8'd0 : cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_NONE;
         cnt_q   <= 8'd0;
         cs_n_o  <= 1'b1;
         rd_n_o  <= 1'b1;
         wr_n_o  <= 1'b1;
         oe_o    <= 1'b0;
      end else begin
         phase_q <= phase_i;
         cnt_q   <= cnt_d;
         cs_n_o  <= (phase_i == PH_NONE);
         wr_n_o  <= !((phase_i == PH_STROBE) && write_i);
         rd_n_o  <= !((phase_i == PH_STROBE) && !write_i);
         oe_o    <= (phase_i != PH_NONE) && write_i;
      end
   end

endmodule

// File: rtl/dm9000a_ctrl.sv
// DM9000A bus controller: chip power-up reset, 25 MHz chip clock, interrupt
// synchroniser and index-then-data register access sequencing.
module dm9000a_ctrl
   import dm9000a_pkg::*;
#(
   parameter int SETUP_CYCLES        = 1,
   parameter int STROBE_CYCLES       = 3,
   parameter int HOLD_CYCLES         = 1,
   parameter int RECOVERY_CYCLES     = 4,
   parameter int RESET_CYCLES        = 1000,
   parameter int POWERUP_WAIT_CYCLES = 2000
) (
   input  logic        clk100,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [7:0]  req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        init_done,
   output logic        irq,
   inout  wire  [15:0] ENET_DATA,
   output logic        ENET_CLK,
   output logic        ENET_CMD,
   output logic        ENET_CS_N,
   output logic        ENET_RD_N,
   output logic        ENET_WR_N,
   input  logic        ENET_INT,
   output logic        ENET_RST_N
);

   localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);
   localparam logic [15:0] PWR_LAST = 16'(POWERUP_WAIT_CYCLES - 1);
   localparam logic [15:0] REC_LAST = 16'(RECOVERY_CYCLES - 1);

   state_e      state_q, state_d;
   logic [15:0] waitCnt_q, waitCnt_d;
   logic        waitLast, phaseLast, accept, busOe, phaseWrite;
   logic        dataDone_q, write_q, cmd_q, cmd_d;
   logic [15:0] wdata_q, dout_q, dout_d, cap_q, rspRdata_q;
   logic [1:0]  clkDiv_q;
   logic        intMeta_q, irq_q, enetRstN_q, reqReady_q, initDone_q, rspValid_q;

   assign accept = req_valid && reqReady_q;

   always_comb begin
      case (state_q)
         RST_HOLD: waitLast = (waitCnt_q == RST_LAST);
         RST_WAIT: waitLast = (waitCnt_q == PWR_LAST);
         default:  waitLast = (waitCnt_q == REC_LAST);
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RST_HOLD:   if (waitLast) state_d = RST_WAIT;
         RST_WAIT:   if (waitLast) state_d = IDLE;
         IDLE:       if (accept) state_d = IDX_SETUP;
         IDX_SETUP:  if (phaseLast) state_d = IDX_STROBE;
         IDX_STROBE: if (phaseLast) state_d = IDX_HOLD;
         IDX_HOLD:   if (phaseLast) state_d = RECOVER;
         DAT_SETUP:  if (phaseLast) state_d = DAT_STROBE;
         DAT_STROBE: if (phaseLast) state_d = DAT_HOLD;
         DAT_HOLD:   if (phaseLast) state_d = RECOVER;
         RECOVER:    if (waitLast) state_d = dataDone_q ? RESP : DAT_SETUP;
         RESP:       state_d = IDLE;
         default:    state_d = RST_HOLD;
      endcase

      waitCnt_d  = (state_d != state_q) ? 16'd0 : waitCnt_q + 16'd1;
      phaseWrite = (phase_of(state_d) != PH_NONE && state_d inside {DAT_SETUP, DAT_STROBE, DAT_HOLD})
                   ? write_q : 1'b1;
      cmd_d      = (state_d inside {DAT_SETUP, DAT_STROBE, DAT_HOLD}) ? CMD_DATA : CMD_INDEX;

      dout_d = dout_q;
      if (accept)
         dout_d = {8'h00, req_addr};
      else if (state_q == RECOVER && state_d == DAT_SETUP)
         dout_d = wdata_q;
   end

   dm9000a_bus_phase #(
      .SETUP_CYCLES  (SETUP_CYCLES),
      .STROBE_CYCLES (STROBE_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES)
   ) u_phase (
      .clk     (clk100),
      .rst_n   (rst_n),
      .phase_i (phase_of(state_d)),
      .write_i (phaseWrite),
      .cs_n_o  (ENET_CS_N),
      .rd_n_o  (ENET_RD_N),
      .wr_n_o  (ENET_WR_N),
      .oe_o    (busOe),
      .last_o  (phaseLast)
   );

   // Read data is sampled on the final strobe cycle and presented only during RESP.
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RST_HOLD;
         waitCnt_q  <= 16'd0;
         dataDone_q <= 1'b0;
         write_q    <= 1'b0;
         wdata_q    <= 16'd0;
         dout_q     <= 16'd0;
         cap_q      <= 16'd0;
         cmd_q      <= CMD_INDEX;
         clkDiv_q   <= 2'd0;
         intMeta_q  <= 1'b0;
         irq_q      <= 1'b0;
         enetRstN_q <= 1'b0;
         reqReady_q <= 1'b0;
         initDone_q <= 1'b0;
         rspValid_q <= 1'b0;
         rspRdata_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         waitCnt_q  <= waitCnt_d;
         dout_q     <= dout_d;
         cmd_q      <= cmd_d;
         clkDiv_q   <= clkDiv_q + 2'd1;
         intMeta_q  <= ENET_INT;
         irq_q      <= intMeta_q;
         enetRstN_q <= (state_d != RST_HOLD);
         reqReady_q <= (state_d == IDLE);
         initDone_q <= initDone_q || (state_d == IDLE);
         rspValid_q <= (state_d == RESP);
         rspRdata_q <= (state_d == RESP && !write_q) ? cap_q : 16'd0;
         if (state_q == DAT_HOLD)
            dataDone_q <= 1'b1;
         else if (state_q == RESP)
            dataDone_q <= 1'b0;
         if (accept) begin
            write_q <= req_write;
            wdata_q <= req_wdata;
         end
         if (state_q == DAT_STROBE && phaseLast && !write_q)
            cap_q <= ENET_DATA;
      end
   end

   assign ENET_DATA  = busOe ? dout_q : 16'hzzzz;
   assign ENET_CLK   = clkDiv_q[1];
   assign ENET_CMD   = cmd_q;
   assign ENET_RST_N = enetRstN_q;
   assign irq        = irq_q;
   assign req_ready  = reqReady_q;
   assign init_done  = initDone_q;
   assign rsp_valid  = rspValid_q;
   assign rsp_rdata  = rspRdata_q;

endmodule

// File: tb/tb_dm9000a_ctrl.sv
// Directed bench for dm9000a_ctrl: register access vectors from a table plus
// hand sequences for power-up, back-to-back, clock/irq and mid-cycle reset.
module tb_dm9000a_ctrl;
   import dm9000a_pkg::*;

   localparam int RST_CYC = 8;
   localparam int PWR_CYC = 8;

   typedef struct {
      logic        write;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] rdModel;
      logic [15:0] expIdx;
      logic [15:0] expDat;
      logic [15:0] expRdata;
   } vec_t;

   logic        clk100 = 1'b0;
   logic        rst_n;
   logic        reqValid, reqWrite, reqReady, rspValid, initDone, irq;
   logic [7:0]  reqAddr;
   logic [15:0] reqWdata, rspRdata;
   wire  [15:0] enetData;
   logic        enetClk, enetCmd, enetCsN, enetRdN, enetWrN, enetInt, enetRstN;
   logic        forceDrive, tbDrive;
   logic [15:0] modelRdata, tbData;
   int          errors = 0;
   int          checks = 0;
   vec_t        vecs[6];

   always #5 clk100 = ~clk100;

   // Chip model: answers reads while RD_N and CS_N are low; forceDrive probes for bus release.
   always_comb begin
      tbDrive = forceDrive || (!enetCsN && !enetRdN);
      tbData  = forceDrive ? 16'h5A5A : modelRdata;
   end
   assign enetData = tbDrive ? tbData : 16'hzzzz;

   dm9000a_ctrl #(
      .RESET_CYCLES        (RST_CYC),
      .POWERUP_WAIT_CYCLES (PWR_CYC)
   ) dut (
      .clk100     (clk100),
      .rst_n      (rst_n),
      .req_valid  (reqValid),
      .req_ready  (reqReady),
      .req_write  (reqWrite),
      .req_addr   (reqAddr),
      .req_wdata  (reqWdata),
      .rsp_valid  (rspValid),
      .rsp_rdata  (rspRdata),
      .init_done  (initDone),
      .irq        (irq),
      .ENET_DATA  (enetData),
      .ENET_CLK   (enetClk),
      .ENET_CMD   (enetCmd),
      .ENET_CS_N  (enetCsN),
      .ENET_RD_N  (enetRdN),
      .ENET_WR_N  (enetWrN),
      .ENET_INT   (enetInt),
      .ENET_RST_N (enetRstN)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic waitReady(input string tag);
      int guard = 0;
      while (!reqReady && guard < 200) begin
         @(negedge clk100);
         guard++;
      end
      checkOutput({tag, "_ready_timeout"}, 32'(guard < 200), 32'd1);
   endtask

   // Called at the negedge where rst_n was just released; requests offered here must be ignored.
   task automatic checkResetSequence(input string tag);
      int rstLow = 0, rstRise = -1, initRise = -1, strobeLow = 0, rspSeen = 0;
      reqWrite = 1'b1;
      reqAddr  = REG_IMR;
      reqWdata = 16'h00FF;
      for (int n = 0; n < 40; n++) begin
         if (n > 0) @(negedge clk100);
         if (n == 2) reqValid = 1'b1;
         if (n == 12) reqValid = 1'b0;
         if (!enetRstN) rstLow++;
         else if (rstRise < 0) rstRise = n;
         if (initDone && initRise < 0) initRise = n;
         if (!enetCsN || !enetRdN || !enetWrN) strobeLow++;
         if (rspValid) rspSeen++;
      end
      checkOutput({tag, "_rst_low_cycles"}, 32'(rstLow), 32'd8);
      checkOutput({tag, "_rst_rise"}, 32'(rstRise), 32'd8);
      checkOutput({tag, "_init_delay"}, 32'(initRise - rstRise), 32'd8);
      checkOutput({tag, "_strobes_idle"}, 32'(strobeLow), 32'd0);
      checkOutput({tag, "_no_rsp"}, 32'(rspSeen), 32'd0);
      checkOutput({tag, "_ready_idle"}, 32'(reqReady), 32'd1);
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      int idxStrobe = 0, datStrobe = 0, wrongStrobe = 0, bothLow = 0;
      int lowRuns = 0, gap = 0, rspAt = -1, rspCount = 0;
      logic [15:0] idxVal = 16'd0, datVal = 16'd0, rdata = 16'd0;
      logic prevCs = 1'b1;
      string tag = $sformatf("vec%0d", idx);
      waitReady(tag);
      reqValid   = 1'b1;
      reqWrite   = v.write;
      reqAddr    = v.addr;
      reqWdata   = v.wdata;
      modelRdata = v.rdModel;
      @(negedge clk100);
      reqValid = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         if (!enetCsN && enetCmd == CMD_INDEX) begin
            if (!enetWrN) begin
               if (idxStrobe == 0) idxVal = enetData;
               idxStrobe++;
            end
            if (!enetRdN) wrongStrobe++;
         end
         if (!enetCsN && enetCmd == CMD_DATA) begin
            if (v.write ? !enetWrN : !enetRdN) begin
               if (datStrobe == 0) datVal = enetData;
               datStrobe++;
            end
            if (v.write ? !enetRdN : !enetWrN) wrongStrobe++;
         end
         if (!enetRdN && !enetWrN) bothLow++;
         if (!enetCsN && prevCs) lowRuns++;
         if (enetCsN && lowRuns == 1) gap++;
         prevCs = enetCsN;
         if (rspValid) begin
            rspCount++;
            if (rspAt < 0) begin
               rspAt = n;
               rdata = rspRdata;
            end
         end
         @(negedge clk100);
      end
      checkOutput({tag, "_idx_strobe"}, 32'(idxStrobe), 32'd3);
      checkOutput({tag, "_idx_data"}, 32'(idxVal), 32'(v.expIdx));
      checkOutput({tag, "_dat_strobe"}, 32'(datStrobe), 32'd3);
      checkOutput({tag, "_dat_data"}, 32'(datVal), 32'(v.expDat));
      checkOutput({tag, "_wrong_strobe"}, 32'(wrongStrobe), 32'd0);
      checkOutput({tag, "_both_low"}, 32'(bothLow), 32'd0);
      checkOutput({tag, "_cs_runs"}, 32'(lowRuns), 32'd2);
      checkOutput({tag, "_recovery_gap"}, 32'(gap), 32'd4);
      checkOutput({tag, "_latency"}, 32'(rspAt), 32'd19);
      checkOutput({tag, "_rsp_pulses"}, 32'(rspCount), 32'd1);
      checkOutput({tag, "_rsp_rdata"}, 32'(rdata), 32'(v.expRdata));
   endtask

   task automatic backToBack();
      int acc1 = -1, acc2 = -1, rsp1 = -1, rsp2 = -1, busyReady = 0;
      int lowRuns = 0, highRun = 0, minGap = 1000;
      logic prevCs = 1'b1;
      logic [15:0] rdata2 = 16'd0;
      waitReady("b2b");
      reqValid   = 1'b1;
      reqWrite   = 1'b1;
      reqAddr    = REG_IMR;
      reqWdata   = 16'h0081;
      modelRdata = 16'h1234;
      for (int n = 0; n < 45; n++) begin
         if (acc1 >= 0 && acc2 < 0 && n == acc1 + 1) begin
            reqWrite = 1'b0;
            reqAddr  = REG_VID;
         end
         if (acc2 >= 0 && n == acc2 + 1) reqValid = 1'b0;
         if (reqReady && reqValid) begin
            if (acc1 < 0) acc1 = n;
            else if (acc2 < 0) acc2 = n;
         end
         if (reqReady && acc1 >= 0 && n > acc1 && n < acc1 + 20) busyReady++;
         if (rspValid) begin
            if (rsp1 < 0) rsp1 = n;
            else begin
               rsp2   = n;
               rdata2 = rspRdata;
            end
         end
         if (!enetCsN && prevCs) begin
            if (lowRuns > 0 && highRun < minGap) minGap = highRun;
            lowRuns++;
         end
         highRun = enetCsN ? highRun + 1 : 0;
         prevCs  = enetCsN;
         @(negedge clk100);
      end
      reqValid = 1'b0;
      checkOutput("b2b_accept1", 32'(acc1), 32'd0);
      checkOutput("b2b_accept2", 32'(acc2), 32'd20);
      checkOutput("b2b_rsp1", 32'(rsp1), 32'd19);
      checkOutput("b2b_rsp2", 32'(rsp2), 32'd39);
      checkOutput("b2b_ready_busy", 32'(busyReady), 32'd0);
      checkOutput("b2b_cs_runs", 32'(lowRuns), 32'd4);
      checkOutput("b2b_min_gap", 32'(minGap), 32'd4);
      checkOutput("b2b_rdata2", 32'(rdata2), 32'h1234);
   endtask

   task automatic clkAndIrq();
      int highs = 0, rises = 0, badGap = 0, lastRise = -1;
      logic prev = enetClk;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk100);
         if (enetClk) highs++;
         if (enetClk && !prev) begin
            rises++;
            if (lastRise >= 0 && n - lastRise != 4) badGap++;
            lastRise = n;
         end
         prev = enetClk;
      end
      checkOutput("enet_clk_highs", 32'(highs), 32'd50);
      checkOutput("enet_clk_rises", 32'(rises), 32'd25);
      checkOutput("enet_clk_period", 32'(badGap), 32'd0);
      enetInt = 1'b1;
      @(negedge clk100);
      checkOutput("irq_rise_1cyc", 32'(irq), 32'd0);
      @(negedge clk100);
      checkOutput("irq_rise_2cyc", 32'(irq), 32'd1);
      repeat (2) @(negedge clk100);
      enetInt = 1'b0;
      @(negedge clk100);
      checkOutput("irq_fall_1cyc", 32'(irq), 32'd1);
      @(negedge clk100);
      checkOutput("irq_fall_2cyc", 32'(irq), 32'd0);
   endtask

   task automatic midReset();
      int guard = 0, rspSeen = 0;
      waitReady("midrst");
      reqValid = 1'b1;
      reqWrite = 1'b1;
      reqAddr  = REG_NCR;
      reqWdata = 16'h1234;
      @(negedge clk100);
      reqValid = 1'b0;
      while (!(enetCmd == CMD_DATA && !enetWrN) && guard < 40) begin
         @(negedge clk100);
         guard++;
      end
      checkOutput("midrst_dat_strobe_found", 32'(guard < 40), 32'd1);
      #2;
      rst_n      = 1'b0;
      forceDrive = 1'b1;
      #1;
      checkOutput("midrst_bus_released", 32'({enetCsN, enetRdN, enetWrN, enetRstN}), 32'b1110);
      checkOutput("midrst_data_z", 32'(enetData), 32'h5A5A);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk100);
         if (rspValid) rspSeen++;
      end
      checkOutput("midrst_no_rsp", 32'(rspSeen), 32'd0);
      forceDrive = 1'b0;
      rst_n      = 1'b1;
      checkResetSequence("replay");
   endtask

   initial begin
      vecs[0] = '{write: 1'b1, addr: REG_IMR,   wdata: 16'h0081, rdModel: 16'h0000,
                  expIdx: 16'h00FF, expDat: 16'h0081, expRdata: 16'h0000};
      vecs[1] = '{write: 1'b0, addr: REG_VID,   wdata: 16'h0000, rdModel: 16'h0A46,
                  expIdx: 16'h0028, expDat: 16'h0A46, expRdata: 16'h0A46};
      vecs[2] = '{write: 1'b1, addr: REG_NCR,   wdata: 16'h0001, rdModel: 16'h0000,
                  expIdx: 16'h0000, expDat: 16'h0001, expRdata: 16'h0000};
      vecs[3] = '{write: 1'b0, addr: REG_ISR,   wdata: 16'h0000, rdModel: 16'h8003,
                  expIdx: 16'h00FE, expDat: 16'h8003, expRdata: 16'h8003};
      vecs[4] = '{write: 1'b1, addr: REG_MWCMD, wdata: 16'hA5C3, rdModel: 16'h0000,
                  expIdx: 16'h00F8, expDat: 16'hA5C3, expRdata: 16'h0000};
      vecs[5] = '{write: 1'b0, addr: REG_MRCMD, wdata: 16'h0000, rdModel: 16'hFFFF,
                  expIdx: 16'h00F2, expDat: 16'hFFFF, expRdata: 16'hFFFF};

      rst_n      = 1'b0;
      reqValid   = 1'b0;
      reqWrite   = 1'b0;
      reqAddr    = 8'h00;
      reqWdata   = 16'h0000;
      forceDrive = 1'b0;
      modelRdata = 16'h0000;
      enetInt    = 1'b0;
      repeat (3) @(negedge clk100);
      checkOutput("reset_outputs",
                  32'({enetCsN, enetRdN, enetWrN, enetCmd, enetRstN, enetClk,
                       reqReady, rspValid, initDone, irq}), 32'b1110000000);
      checkOutput("reset_rdata", 32'(rspRdata), 32'd0);
      rst_n = 1'b1;
      checkResetSequence("powerup");

      for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

      backToBack();
      clkAndIrq();
      midReset();
      applyStimulus(vecs[1], 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dm9000a_ctrl.md
Name: dm9000a_ctrl

Overview:
Bus-level controller for the DM9000A Ethernet MAC/PHY chip on the board's ENET_* pins, clocked from the 100 MHz PLL clock. It performs the chip's power-up reset, generates the 25 MHz chip clock, synchronises the interrupt line, and serialises host register read/write requests into the chip's index-then-data bus cycles. Upstream packet builders (the sampling/packet-generation logic) use it as their only path to the chip.

Parameters:
SETUP_CYCLES, 1, clk100 cycles with CS_N low and address/data stable before the RD_N/WR_N strobe
STROBE_CYCLES, 3, clk100 cycles that RD_N or WR_N is held low
HOLD_CYCLES, 1, cycles after the strobe rises before CS_N rises and data is released
RECOVERY_CYCLES, 4, idle cycles (CS_N high) between any two bus cycles
RESET_CYCLES, 1000, cycles ENET_RST_N is held low after reset (10 us)
POWERUP_WAIT_CYCLES, 2000, cycles waited after ENET_RST_N rises before accepting requests

Ports:
clk100  in  1  100 MHz system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  controller can accept a request
req_write  in  1  1 = register write, 0 = register read
req_addr  in  8  DM9000A register index
req_wdata  in  16  write data
rsp_valid  out  1  one-cycle pulse: request finished
rsp_rdata  out  16  read data; valid with rsp_valid on reads, 0 on writes
init_done  out  1  chip reset/power-up sequence complete
irq  out  1  ENET_INT after a two-flop synchroniser
ENET_DATA  inout  16  chip data bus; driven only during write phases, else Z
ENET_CLK  out  1  25 MHz chip clock (clk100 / 4)
ENET_CMD  out  1  0 = index cycle, 1 = data cycle
ENET_CS_N  out  1  chip select, active low
ENET_RD_N  out  1  read strobe, active low
ENET_WR_N  out  1  write strobe, active low
ENET_INT  in  1  chip interrupt, asynchronous
ENET_RST_N  out  1  chip reset, active low

Behaviour:
- Single clock domain, clk100. Reset is asynchronous and active-low (rst_n). All outputs are registered.
- Values in reset: CS_N=RD_N=WR_N=1, CMD=0, RST_N=0, ENET_DATA=Z, ENET_CLK=0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, irq=0.
- ENET_CLK: 2-bit free-running counter, output bit[1]. Period 4 clk100 cycles, 50% duty. Independent of the FSM.
- FSM states:
  - RST_HOLD: RST_N low for RESET_CYCLES cycles.
  - RST_WAIT: RST_N high, wait POWERUP_WAIT_CYCLES cycles.
  - IDLE: init_done=1, req_ready=1.
  - IDX_SETUP, IDX_STROBE, IDX_HOLD: index phase.
  - DAT_SETUP, DAT_STROBE, DAT_HOLD: data phase.
  - RECOVER: CS_N high for RECOVERY_CYCLES cycles.
  - RESP: rsp_valid=1 for exactly one cycle, then return to IDLE.
- Handshake: a request is accepted when req_valid && req_ready. Address, data and direction are latched on acceptance. req_ready drops on the next cycle and stays low until the FSM is back in IDLE.
- Index phase: CMD=0, ENET_DATA driven with {8'h00, addr}, CS_N low through setup, strobe and hold, WR_N low during strobe.
- Between phases: CS_N high for RECOVERY_CYCLES cycles.
- Data phase, write: CMD=1, ENET_DATA driven with wdata, WR_N strobe.
- Data phase, read: CMD=1, ENET_DATA released (Z), RD_N strobe. ENET_DATA is captured on the last strobe cycle.
- Bus rules: RD_N and WR_N are never low together. The data driver is enabled only while CS_N is low in a write phase.
- Total request latency, acceptance to rsp_valid: 2*(SETUP+STROBE+HOLD) + 2*RECOVERY + 1 = 19 cycles at default parameters.
- Requests are ignored (not latched) while init_done=0.
- rst_n asserted mid-transaction: all bus strobes are deasserted immediately, the sequence restarts from RST_HOLD, and no rsp_valid is issued.
- irq follows ENET_INT with 2-cycle latency, level-sensitive.

Decomposition:
- Package dm9000a_pkg holds:
  - FSM state enum
  - DM9000A register index constants (NCR 8'h00, NSR 8'h01, TCR 8'h02, ISR 8'hFE, IMR 8'hFF, MWCMD 8'hF8, MRCMD 8'hF2, VID 8'h28)
  - CMD_INDEX/CMD_DATA constants
- One natural sub-module: dm9000a_bus_phase, a generic setup/strobe/hold timer driving CS_N/strobe/output-enable, instantiated once and reused for both phases.

Test Plan:
1. Reset with RESET_CYCLES=8, POWERUP_WAIT_CYCLES=8: ENET_RST_N low for 8 cycles, then high. init_done and req_ready rise 8 cycles later. Bus strobes stay high throughout.
2. Write addr 8'hFF, data 16'h0081: index cycle shows CMD=0, DATA=16'h00FF, WR_N low for 3 cycles. Data cycle shows CMD=1, DATA=16'h0081. rsp_valid pulses 19 cycles after acceptance with rsp_rdata=0.
3. Read addr 8'h28, bench model drives 16'h0A46 while RD_N is low: DATA is Z during the read phase and rsp_rdata=16'h0A46 with rsp_valid.
4. Back-to-back requests with req_valid held high: second is accepted only after RESP. CS_N is high for at least 4 cycles between every phase.
5. ENET_CLK check: period of 4 clk100 cycles measured over 100 cycles. ENET_INT pulse 1→0 appears on irq 2 cycles later.
6. rst_n pulled low during DAT_STROBE: WR_N, RD_N and CS_N go high immediately, ENET_DATA goes Z, no rsp_valid, and the full reset sequence replays.
